// File: rtl/xaui_pkg.sv
// Shared XGMII/XAUI code points and the idle-randomisation LFSR step used by
// the XAUI transmit column encoder.
package xaui_pkg;

  localparam logic [7:0] XAUI_K      = 8'hBC;
  localparam logic [7:0] XAUI_A      = 8'h7C;
  localparam logic [7:0] XAUI_R      = 8'h1C;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;

  // x^7 + x^6 + 1, one step per column; never leaves a non-zero state.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/xaui_tx_col_enc.sv
// Combinational encoder for one XGMII column (four lanes, one time slot).
module xaui_tx_col_enc
  import xaui_pkg::*;
(
  input  logic [31:0] col_d,
  input  logic [3:0]  col_c,
  input  logic        a_pending,
  input  logic        prev_term,
  input  logic        lfsr_bit,
  output logic [31:0] enc_d,
  output logic [3:0]  enc_k,
  output logic        is_term,
  output logic        took_a
);

  logic [3:0] idle_b;
  logic [3:0] term_b;
  logic       idle;

  // Per-lane classification of idle and terminate bytes.
  always_comb begin
    idle_b = 4'h0;
    term_b = 4'h0;
    for (int l = 0; l < 4; l++) begin
      idle_b[l] = col_c[l] & (col_d[8*l +: 8] == XGMII_IDLE);
      term_b[l] = col_c[l] & (col_d[8*l +: 8] == XGMII_TERM);
    end
  end

  assign idle    = &idle_b;
  assign is_term = |term_b;
  assign took_a  = idle & a_pending;

  // Whole-column idle substitution, otherwise byte-wise control sanitising.
  always_comb begin
    enc_d = 32'h0;
    enc_k = 4'hF;
    if (idle) begin
      if (a_pending) begin
        enc_d = {4{XAUI_A}};
      end else if (prev_term || lfsr_bit) begin
        enc_d = {4{XAUI_K}};
      end else begin
        enc_d = {4{XAUI_R}};
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (!col_c[l]) begin
          enc_d[8*l +: 8] = col_d[8*l +: 8];
          enc_k[l]        = 1'b0;
        end else begin
          case (col_d[8*l +: 8])
            XGMII_START, XGMII_TERM,
            XGMII_ERR,   XGMII_SEQ:  enc_d[8*l +: 8] = col_d[8*l +: 8];
            XGMII_IDLE:              enc_d[8*l +: 8] = XAUI_K;
            default:                 enc_d[8*l +: 8] = XGMII_ERR;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/xaui_tx_encoder.sv
// XGMII-to-XAUI transmit encoder: two chained columns per mgt_clk cycle with
// the ||A||/||K||/||R|| idle sequence and a comma-only stream while disabled.
module xaui_tx_encoder
  import xaui_pkg::*;
#(
  parameter logic [6:0] LFSR_SEED = 7'h7F,
  parameter int         A_MIN     = 16
) (
  input  logic        mgt_clk,
  input  logic        mgt_reset_n,
  input  logic        tx_en,
  input  logic [63:0] xgmii_txd,
  input  logic [7:0]  xgmii_txc,
  output logic [63:0] mgt_txdata,
  output logic [7:0]  mgt_txcharisk,
  output logic        a_sent
);

  localparam logic [4:0] A_MIN_W = 5'(A_MIN);

  logic [4:0]  a_cnt_r, cnt_mid_s, cnt_nxt_s;
  logic        a_pending_r, pend_mid_s, pend_nxt_s;
  logic [6:0]  lfsr_r, lfsr_mid_s, lfsr_nxt_s;
  logic        prev_term_r;
  logic [31:0] c0_d_s, c1_d_s, e0_d_s, e1_d_s;
  logic [3:0]  c0_c_s, c1_c_s, e0_k_s, e1_k_s;
  logic        term0_s, term1_s, took0_s, took1_s;
  logic [63:0] out_d_s;
  logic [7:0]  out_k_s;

  // Split the lane-interleaved XGMII word into two columns and merge back.
  always_comb begin
    c0_d_s  = 32'h0;
    c1_d_s  = 32'h0;
    c0_c_s  = 4'h0;
    c1_c_s  = 4'h0;
    out_d_s = 64'h0;
    out_k_s = 8'h0;
    for (int l = 0; l < 4; l++) begin
      c0_d_s[8*l +: 8]      = xgmii_txd[16*l +: 8];
      c1_d_s[8*l +: 8]      = xgmii_txd[16*l+8 +: 8];
      c0_c_s[l]             = xgmii_txc[2*l];
      c1_c_s[l]             = xgmii_txc[2*l+1];
      out_d_s[16*l +: 8]    = e0_d_s[8*l +: 8];
      out_d_s[16*l+8 +: 8]  = e1_d_s[8*l +: 8];
      out_k_s[2*l]          = e0_k_s[l];
      out_k_s[2*l+1]        = e1_k_s[l];
    end
  end

  xaui_tx_col_enc u_col0 (
    .col_d     (c0_d_s),
    .col_c     (c0_c_s),
    .a_pending (a_pending_r),
    .prev_term (prev_term_r),
    .lfsr_bit  (lfsr_r[0]),
    .enc_d     (e0_d_s),
    .enc_k     (e0_k_s),
    .is_term   (term0_s),
    .took_a    (took0_s)
  );

  // A-counter/LFSR state after column 0; column 1 sees it the same cycle.
  always_comb begin
    lfsr_mid_s = lfsr_step(lfsr_r);
    if (took0_s) begin
      cnt_mid_s  = A_MIN_W + {1'b0, lfsr_r[3:0]};
      pend_mid_s = 1'b0;
    end else if (a_cnt_r != 5'd0) begin
      cnt_mid_s  = a_cnt_r - 5'd1;
      pend_mid_s = a_pending_r | (a_cnt_r == 5'd1);
    end else begin
      cnt_mid_s  = a_cnt_r;
      pend_mid_s = a_pending_r;
    end
  end

  xaui_tx_col_enc u_col1 (
    .col_d     (c1_d_s),
    .col_c     (c1_c_s),
    .a_pending (pend_mid_s),
    .prev_term (term0_s),
    .lfsr_bit  (lfsr_mid_s[0]),
    .enc_d     (e1_d_s),
    .enc_k     (e1_k_s),
    .is_term   (term1_s),
    .took_a    (took1_s)
  );

  // A-counter/LFSR state after column 1, to be registered.
  always_comb begin
    lfsr_nxt_s = lfsr_step(lfsr_mid_s);
    if (took1_s) begin
      cnt_nxt_s  = A_MIN_W + {1'b0, lfsr_mid_s[3:0]};
      pend_nxt_s = 1'b0;
    end else if (cnt_mid_s != 5'd0) begin
      cnt_nxt_s  = cnt_mid_s - 5'd1;
      pend_nxt_s = pend_mid_s | (cnt_mid_s == 5'd1);
    end else begin
      cnt_nxt_s  = cnt_mid_s;
      pend_nxt_s = pend_mid_s;
    end
  end

  // Registered outputs and idle-sequence state; frozen while tx_en is low.
  always_ff @(posedge mgt_clk or negedge mgt_reset_n) begin
    if (!mgt_reset_n) begin
      mgt_txdata    <= {8{XAUI_K}};
      mgt_txcharisk <= 8'hFF;
      a_sent        <= 1'b0;
      a_cnt_r       <= A_MIN_W;
      a_pending_r   <= 1'b0;
      lfsr_r        <= LFSR_SEED;
      prev_term_r   <= 1'b0;
    end else if (tx_en) begin
      mgt_txdata    <= out_d_s;
      mgt_txcharisk <= out_k_s;
      a_sent        <= took0_s | took1_s;
      a_cnt_r       <= cnt_nxt_s;
      a_pending_r   <= pend_nxt_s;
      lfsr_r        <= lfsr_nxt_s;
      prev_term_r   <= term1_s;
    end else begin
      mgt_txdata    <= {8{XAUI_K}};
      mgt_txcharisk <= 8'hFF;
      a_sent        <= 1'b0;
      prev_term_r   <= 1'b0;
    end
  end

endmodule
